// File: rtl/l2_block_responder_if.sv
// Request/response bundle between an L1D controller (master) and the L2 block responder (slave).
interface l2_block_responder_if #(
  parameter int BLK_W = 256
);
  // Handshake: the master raises read_l2 or write_l2 together with addr/wdata and holds
  // them until it sees the one-cycle l2_ack; l2_ack is the only completion signal and
  // carries rdata for reads. The slave samples requests only while idle.
  logic             read_l2;
  logic             write_l2;
  logic [31:0]      addr;
  logic [BLK_W-1:0] wdata;
  logic             l2_ack;
  logic [BLK_W-1:0] rdata;
  logic             busy;

  modport master (
    output read_l2, write_l2, addr, wdata,
    input  l2_ack, rdata, busy
  );

  modport slave (
    input  read_l2, write_l2, addr, wdata,
    output l2_ack, rdata, busy
  );
endinterface

// File: rtl/l2_block_responder.sv
// Fixed-latency L2 block responder: one read or write at a time, served from an internal block array.
// Optional completion counters are compiled in with `define L2_BLOCK_RESPONDER_STATS_EN.
module l2_block_responder #(
  parameter int LATENCY = 8,
  parameter int IDX_W   = 8,
  parameter int BLK_W   = 256
) (
  input  logic                clk,
  input  logic                reset,
  l2_block_responder_if.slave bus,
  output logic [31:0]         rd_count,
  output logic [31:0]         wr_count,
  output logic [1:0]          state_dbg
);

  localparam logic [7:0] LOAD = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       cnt_q;
  logic             op_wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [BLK_W-1:0] wdata_q;
  logic [BLK_W-1:0] rdata_q;
  logic             ack_q;
  logic             accept;
  logic             accept_wr;
  logic             finish;

  logic [BLK_W-1:0] mem [2**IDX_W];

  // Tag and offset bits never reach the array; blocks alias on index alone.
  logic unused_addr;
  assign unused_addr = ^{bus.addr[31:5+IDX_W], bus.addr[4:0]};

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    accept_wr = 1'b0;
    finish    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.write_l2) begin
          accept    = 1'b1;
          accept_wr = 1'b1;
          state_d   = ST_WAIT;
        end else if (bus.read_l2) begin
          accept  = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 8'd0) begin
          finish  = 1'b1;
          state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= finish;
      if (accept) begin
        op_wr_q <= accept_wr;
        idx_q   <= bus.addr[5+IDX_W-1:5];
        wdata_q <= bus.wdata;
        cnt_q   <= LOAD;
      end else if (state_q == ST_WAIT && cnt_q != 8'd0) begin
        cnt_q <= cnt_q - 8'd1;
      end
      if (finish && !op_wr_q) rdata_q <= mem[idx_q];
    end
  end

  // Array has no reset; a reset on the completion edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && finish && op_wr_q) mem[idx_q] <= wdata_q;
  end

`ifdef L2_BLOCK_RESPONDER_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt_q <= 32'd0;
      wr_cnt_q <= 32'd0;
    end else if (finish) begin
      if (op_wr_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else         rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 32'd0;
  assign wr_count = 32'd0;
`endif

  assign bus.l2_ack = ack_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = (state_q != ST_IDLE);
  assign state_dbg  = state_q;

endmodule
